// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply/divide engine: shift-add multiply and restoring divide
// at one bit per clock, with sign correction and a one-cycle {Hi,Lo} write strobe.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [1:0]           Op,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 Busy,
    output logic                 Done,
    output logic                 HiLoEn,
    output logic [2*WIDTH-1:0]   HiLoWrite,
    output logic                 DivZero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + ONE_2W;
    endfunction

    // 0x80000000 maps onto itself, which is exactly the unsigned magnitude we need
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? neg_w(v) : v;
    endfunction

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH:0]     acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               hilo_en_q, hilo_en_d;
    logic               div_zero_q, div_zero_d;
    logic [2*WIDTH-1:0] hilo_write_q, hilo_write_d;

    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic [2*WIDTH-1:0] product_s;
    logic [WIDTH-1:0]   orig_a_s;
    logic               div_by_zero_s;

    // Multiply keeps {partial product, remaining multiplier} in acc_hi/acc_lo;
    // divide keeps {remainder, dividend shifting into quotient} in the same pair.
    assign mag_a_s       = magnitude(A, Op[0]);
    assign mag_b_s       = magnitude(B, Op[0]);
    assign mul_sum_s     = acc_hi_q + (acc_lo_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
    assign div_shift_s   = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
    assign div_diff_s    = div_shift_s - {1'b0, opb_q};
    assign product_s     = {acc_hi_q[WIDTH-1:0], acc_lo_q};
    assign orig_a_s      = sign_a_q ? neg_w(opa_q) : opa_q;
    assign div_by_zero_s = op_q[1] && (opb_q == {WIDTH{1'b0}});

    // Next-state, datapath and output-flop computation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        sign_a_d     = sign_a_q;
        sign_b_d     = sign_b_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        acc_hi_d     = acc_hi_q;
        acc_lo_d     = acc_lo_q;
        hilo_write_d = hilo_write_q;
        busy_d       = (state_q == S_CALC) || (state_q == S_FIX);
        done_d       = (state_q == S_DONE);
        hilo_en_d    = (state_q == S_DONE);
        div_zero_d   = (state_q == S_DONE) && div_by_zero_s;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    op_d     = Op;
                    sign_a_d = Op[0] & A[WIDTH-1];
                    sign_b_d = Op[0] & B[WIDTH-1];
                    opa_d    = mag_a_s;
                    opb_d    = mag_b_s;
                    acc_hi_d = {(WIDTH+1){1'b0}};
                    acc_lo_d = Op[1] ? mag_a_s : mag_b_s;
                    cnt_d    = CNT_LAST;
                    state_d  = S_CALC;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_CALC: begin
                if (op_q[1]) begin
                    if (!div_diff_s[WIDTH]) begin
                        acc_hi_d = div_diff_s;
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = div_shift_s;
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_hi_d = {1'b0, mul_sum_s[WIDTH:1]};
                    acc_lo_d = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
                end
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_FIX: begin
                // Divide by zero reports the untouched dividend and an all-ones quotient
                if (div_by_zero_s) begin
                    hilo_write_d = {orig_a_s, {WIDTH{1'b1}}};
                end else if (op_q[1]) begin
                    hilo_write_d = {sign_a_q ? neg_w(acc_hi_q[WIDTH-1:0]) : acc_hi_q[WIDTH-1:0],
                                    (sign_a_q ^ sign_b_q) ? neg_w(acc_lo_q) : acc_lo_q};
                end else begin
                    hilo_write_d = (sign_a_q ^ sign_b_q) ? neg_2w(product_s) : product_s;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= {CW{1'b0}};
            op_q         <= 2'b00;
            sign_a_q     <= 1'b0;
            sign_b_q     <= 1'b0;
            opa_q        <= {WIDTH{1'b0}};
            opb_q        <= {WIDTH{1'b0}};
            acc_hi_q     <= {(WIDTH+1){1'b0}};
            acc_lo_q     <= {WIDTH{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            hilo_en_q    <= 1'b0;
            div_zero_q   <= 1'b0;
            hilo_write_q <= {(2*WIDTH){1'b0}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            sign_a_q     <= sign_a_d;
            sign_b_q     <= sign_b_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            acc_hi_q     <= acc_hi_d;
            acc_lo_q     <= acc_lo_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            hilo_en_q    <= hilo_en_d;
            div_zero_q   <= div_zero_d;
            hilo_write_q <= hilo_write_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign HiLoEn    = hilo_en_q;
    assign DivZero   = div_zero_q;
    assign HiLoWrite = hilo_write_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomized checks of mul_div_unit against a plain-arithmetic model.
module tb_mul_div_unit;
    logic        Clk;
    logic        Rst;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic        HiLoEn;
    logic [63:0] HiLoWrite;
    logic        DivZero;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start_cyc;
    int          done_cyc;
    logic [64:0] exp_res;

    mul_div_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .HiLoEn(HiLoEn), .HiLoWrite(HiLoWrite), .DivZero(DivZero)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    // Reference: {DivZero, Hi, Lo} from ordinary integer arithmetic
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb, q, r;
        case (op)
            2'b00: begin
                p = {32'd0, a} * {32'd0, b};
                return {1'b0, p};
            end
            2'b01: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
                return {1'b0, p};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                if (op == 2'b10) return {1'b0, a % b, a / b};
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = sa / sb;
                r  = sa % sb;
                p  = {32'(r), 32'(q)};
                return {1'b0, p};
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called at a falling edge; Start is sampled on the following rising edge.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold);
        Start   = 1'b1;
        Op      = op;
        A       = a;
        B       = b;
        exp_res = model(op, a, b);
        @(negedge Clk);
        start_cyc = cyc;
        Start = hold;
        A     = $urandom;
        B     = $urandom;
        Op    = 2'($urandom_range(0, 3));
        check("busy_at_start_edge", {63'd0, Busy}, 64'd0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (Done !== 1'b1 && n < 60) begin
            @(negedge Clk);
            n++;
            if (n == 1) check({tag, "_busy"}, {63'd0, Busy}, 64'd1);
        end
        done_cyc = cyc;
        check({tag, "_latency"}, 64'(cyc - start_cyc), 64'd34);
        check({tag, "_strobe"}, {61'd0, Busy, HiLoEn, Done}, 64'd3);
        check({tag, "_result"}, HiLoWrite, exp_res[63:0]);
        check({tag, "_divzero"}, {63'd0, DivZero}, {63'd0, exp_res[64]});
    endtask

    task automatic pulse_end(input string tag);
        @(negedge Clk);
        check({tag, "_pulse_end"}, {62'd0, HiLoEn, Done}, 64'd0);
        check({tag, "_hold"}, HiLoWrite, exp_res[63:0]);
    endtask

    initial begin
        int          seen;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        Rst = 1'b0; Start = 1'b0; Op = 2'b00; A = 32'd0; B = 32'd0;
        #2;
        check("reset_outputs", {HiLoWrite[62:0], Busy} | {63'd0, Done | HiLoEn | DivZero}, 64'd0);
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);

        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max_model", exp_res[63:0], 64'hFFFF_FFFE_0000_0001);
        wait_done("multu_max");
        pulse_end("multu_max");

        launch(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0);
        wait_done("mult_neg");
        pulse_end("mult_neg");
        launch(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_done("div_neg");
        pulse_end("div_neg");

        launch(2'b10, 32'd100, 32'd0, 1'b0);
        wait_done("divu_zero");
        pulse_end("divu_zero");
        launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done("div_ovf");
        pulse_end("div_ovf");

        // Start held high throughout, operands changed mid-operation
        launch(2'b10, 32'd100, 32'd7, 1'b1);
        A = 32'd5; B = 32'd5;
        wait_done("divu_hold");
        Start = 1'b0;
        @(negedge Clk);
        check("hold_no_restart_a", {63'd0, Busy}, 64'd0);
        @(negedge Clk);
        check("hold_no_restart_b", {63'd0, Busy}, 64'd0);

        // Asynchronous reset in the middle of CALC
        launch(2'b00, 32'd3, 32'd5, 1'b0);
        repeat (10) @(negedge Clk);
        #2 Rst = 1'b0;
        #1;
        check("async_reset_flags", {60'd0, Busy, Done, HiLoEn, DivZero}, 64'd0);
        check("async_reset_data", HiLoWrite, 64'd0);
        @(negedge Clk);
        Rst = 1'b1;
        seen = 0;
        repeat (45) begin
            @(negedge Clk);
            if (Done || HiLoEn) seen++;
        end
        check("no_strobe_after_reset", 64'(seen), 64'd0);
        launch(2'b00, 32'd3, 32'd5, 1'b0);
        wait_done("multu_fresh");
        pulse_end("multu_fresh");

        // Back-to-back: next Start presented during the Done cycle
        launch(2'b01, 32'h1234_5678, 32'hFEDC_BA98, 1'b0);
        wait_done("b2b_first");
        seen = done_cyc;
        launch(2'b11, 32'h8765_4321, 32'h0000_0123, 1'b0);
        wait_done("b2b_second");
        check("b2b_spacing", 64'(done_cyc - seen), 64'd35);
        pulse_end("b2b_second");

        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 5 == 1) rb = 32'd0;
            if (i % 5 == 3) ra = 32'h8000_0000;
            if (i % 7 == 2) rb = 32'hFFFF_FFFF;
            if (i % 4 == 0) rb = rb >> $urandom_range(0, 31);
            launch(rop, ra, rb, 1'b0);
            wait_done("random");
            pulse_end("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
